// File: rtl/mssd_tx.sv
// MSSD serial frame transmitter: start bit, 2-bit dest, 4-bit length, 8*N payload bits, MSB first.
// Optional post-frame guard interval is compiled in with MSSD_TX_GUARD_EN.
module mssd_tx #(
    parameter logic IDLE_LVL = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frm_valid,
    output logic       frm_ready,
    input  logic [1:0] frm_dest,
    input  logic [3:0] frm_len,
    input  logic       byte_valid,
    output logic       byte_ready,
    input  logic [7:0] byte_data,
    output logic       serOut,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       underrun
);
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DEST  = 3'd2,
        ST_LEN   = 3'd3,
        ST_DATA  = 3'd4,
        ST_GUARD = 3'd5
    } state_t;

    state_t     state_r, state_s;
    logic [1:0] dest_r, dest_s;
    logic [3:0] len_r, len_s;
    logic [2:0] bit_cnt_r, bit_cnt_s, dec_s;
    logic [3:0] byte_cnt_r, byte_cnt_s;
    logic [3:0] fetch_cnt_r, fetch_cnt_s;
    logic [7:0] sh_r, sh_s, hb_r, hb_s, load_s;
    logic       hb_full_r, hb_full_s;
    logic       ser_r, ser_s;
    logic       frm_ready_r, frm_ready_s;
    logic       byte_ready_r, byte_ready_s;
    logic       busy_r, busy_s, done_r, done_s;
    logic       err_r, err_s, underrun_r, underrun_s;
    logic       take_s, boundary_s;

    // Every output is computed for the coming cycle and registered, so the line never glitches.
    always_comb begin
        state_s     = state_r;
        dest_s      = dest_r;
        len_s       = len_r;
        bit_cnt_s   = bit_cnt_r;
        byte_cnt_s  = byte_cnt_r;
        fetch_cnt_s = fetch_cnt_r;
        sh_s        = sh_r;
        hb_s        = hb_r;
        hb_full_s   = hb_full_r;
        ser_s       = IDLE_LVL;
        err_s       = 1'b0;
        underrun_s  = 1'b0;
        boundary_s  = 1'b0;
        load_s      = 8'h00;
        dec_s       = bit_cnt_r - 3'd1;
        take_s      = byte_valid && byte_ready_r;

        case (state_r)
            ST_IDLE: begin
                if (frm_valid && frm_ready_r) begin
                    if (frm_len == 4'd0) begin
                        err_s = 1'b1;
                    end else begin
                        dest_s      = frm_dest;
                        len_s       = frm_len;
                        fetch_cnt_s = 4'd0;
                        byte_cnt_s  = 4'd0;
                        hb_full_s   = 1'b0;
                        state_s     = ST_START;
                        ser_s       = ~IDLE_LVL;
                    end
                end else begin
                    ser_s = IDLE_LVL;
                end
            end
            ST_START: begin
                state_s   = ST_DEST;
                bit_cnt_s = 3'd1;
                ser_s     = dest_r[1];
            end
            ST_DEST: begin
                if (bit_cnt_r != 3'd0) begin
                    bit_cnt_s = 3'd0;
                    ser_s     = dest_r[0];
                end else begin
                    state_s   = ST_LEN;
                    bit_cnt_s = 3'd3;
                    ser_s     = len_r[3];
                end
            end
            ST_LEN: begin
                if (bit_cnt_r != 3'd0) begin
                    bit_cnt_s = dec_s;
                    ser_s     = len_r[dec_s[1:0]];
                end else begin
                    state_s    = ST_DATA;
                    bit_cnt_s  = 3'd7;
                    byte_cnt_s = 4'd1;
                    boundary_s = 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_cnt_r != 3'd0) begin
                    bit_cnt_s = dec_s;
                    ser_s     = sh_r[7];
                    sh_s      = {sh_r[6:0], 1'b0};
                end else if (byte_cnt_r == len_r) begin
`ifdef MSSD_TX_GUARD_EN
                    state_s   = ST_GUARD;
                    bit_cnt_s = 3'd1;
`else
                    state_s   = ST_IDLE;
`endif
                end else begin
                    bit_cnt_s  = 3'd7;
                    byte_cnt_s = byte_cnt_r + 4'd1;
                    boundary_s = 1'b1;
                end
            end
            ST_GUARD: begin
                if (bit_cnt_r != 3'd0) begin
                    bit_cnt_s = dec_s;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // Byte boundary: holding buffer first, then a same-cycle bypass, else send zeros.
        if (boundary_s) begin
            if (hb_full_r) begin
                load_s    = hb_r;
                hb_full_s = 1'b0;
            end else if (take_s) begin
                load_s      = byte_data;
                fetch_cnt_s = fetch_cnt_r + 4'd1;
            end else begin
                load_s     = 8'h00;
                underrun_s = 1'b1;
                if (fetch_cnt_r < len_r) begin
                    fetch_cnt_s = fetch_cnt_r + 4'd1;
                end else begin
                    fetch_cnt_s = fetch_cnt_r;
                end
            end
            ser_s = load_s[7];
            sh_s  = {load_s[6:0], 1'b0};
        end else if (take_s) begin
            hb_s        = byte_data;
            hb_full_s   = 1'b1;
            fetch_cnt_s = fetch_cnt_r + 4'd1;
        end else begin
            hb_s = hb_r;
        end

        busy_s       = (state_s != ST_IDLE);
        frm_ready_s  = (state_s == ST_IDLE);
        byte_ready_s = busy_s && !hb_full_s && (fetch_cnt_s < len_s);
        done_s       = (state_s == ST_DATA) && (bit_cnt_s == 3'd0) && (byte_cnt_s == len_s);
    end

    // State, datapath and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            dest_r       <= 2'd0;
            len_r        <= 4'd0;
            bit_cnt_r    <= 3'd0;
            byte_cnt_r   <= 4'd0;
            fetch_cnt_r  <= 4'd0;
            sh_r         <= 8'h00;
            hb_r         <= 8'h00;
            hb_full_r    <= 1'b0;
            ser_r        <= IDLE_LVL;
            frm_ready_r  <= 1'b0;
            byte_ready_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            underrun_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            dest_r       <= dest_s;
            len_r        <= len_s;
            bit_cnt_r    <= bit_cnt_s;
            byte_cnt_r   <= byte_cnt_s;
            fetch_cnt_r  <= fetch_cnt_s;
            sh_r         <= sh_s;
            hb_r         <= hb_s;
            hb_full_r    <= hb_full_s;
            ser_r        <= ser_s;
            frm_ready_r  <= frm_ready_s;
            byte_ready_r <= byte_ready_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            err_r        <= err_s;
            underrun_r   <= underrun_s;
        end
    end

    assign serOut     = ser_r;
    assign frm_ready  = frm_ready_r;
    assign byte_ready = byte_ready_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign err        = err_r;
    assign underrun   = underrun_r;
endmodule

// File: tb/tb_mssd_tx.sv
// Self-checking bench for mssd_tx: directed frames plus randomized frames against a frame-level model.
module tb_mssd_tx;
    localparam logic IDLE = 1'b1;
`ifdef MSSD_TX_GUARD_EN
    localparam int GUARD = 2;
`else
    localparam int GUARD = 0;
`endif

    logic       clk = 1'b0;
    logic       rst, frm_valid, frm_ready, byte_valid, byte_ready;
    logic [1:0] frm_dest;
    logic [3:0] frm_len;
    logic [7:0] byte_data;
    logic       serOut, busy, done, err, underrun;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_done = 0;
    bit last_bits[$];

    mssd_tx dut (
        .clk(clk), .rst(rst), .frm_valid(frm_valid), .frm_ready(frm_ready),
        .frm_dest(frm_dest), .frm_len(frm_len), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .byte_data(byte_data), .serOut(serOut),
        .busy(busy), .done(done), .err(err), .underrun(underrun)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", tag, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    function automatic int pick_gap(input int gap_fix);
        if (gap_fix < 0) return int'($urandom_range(0, 3));
        return gap_fix;
    endfunction

    task automatic idle_cycle();
        step();
        check_val("idle_ser", serOut, IDLE);
        check_val("idle_busy", busy, 0);
        check_val("idle_frm_ready", frm_ready, 1);
    endtask

    // Sends one frame; the payload slots set in wh are never offered (expected underrun).
    task automatic run_frame(input logic [1:0] d, input logic [3:0] n, input logic [15:0] wh,
                             input int gap_fix, input int first_byte, input bit check_gap);
        logic [7:0] pay [16];
        bit exp_bits[$];
        logic [7:0] v;
        int nn, t0, k, gap, hs, w, nwh, last_o;
        nn = n;
        nwh = 0;
        for (int s = 0; s < 16; s++) pay[s] = 8'($urandom_range(0, 255));
        if (first_byte >= 0) pay[0] = 8'(first_byte);
        exp_bits.push_back(~IDLE);
        exp_bits.push_back(d[1]);
        exp_bits.push_back(d[0]);
        for (int b = 3; b >= 0; b--) exp_bits.push_back(n[b]);
        for (int s = 0; s < nn; s++) begin
            v = wh[s] ? 8'h00 : pay[s];
            if (wh[s]) nwh++;
            for (int b = 7; b >= 0; b--) exp_bits.push_back(v[b]);
        end
        frm_dest = d;
        frm_len = n;
        frm_valid = 1'b1;
        w = 0;
        while (frm_ready !== 1'b1 && w < 40) begin
            step();
            w++;
        end
        check_val("accept_ready", frm_ready, 1);
        if (frm_ready !== 1'b1) begin
            frm_valid = 1'b0;
            return;
        end
        t0 = cyc;
        if (check_gap) check_val("frame_gap", t0 + 1 - last_done, 2 + GUARD);
        k = 0;
        hs = 0;
        gap = pick_gap(gap_fix);
        last_o = 7 + 8 * nn;
        last_bits.delete();
        for (int o = 1; o <= last_o + 1 + GUARD; o++) begin
            step();
            frm_valid = 1'b0;
            if (o <= last_o) begin
                check_val("ser_bit", serOut, exp_bits[o-1]);
                last_bits.push_back(serOut);
                check_val("busy_frame", busy, 1);
                check_val("frm_ready_frame", frm_ready, 0);
                check_val("done", done, (o == last_o));
                check_val("underrun", underrun,
                          (o >= 8 && (o - 8) % 8 == 0 && wh[(o-8)/8]));
            end else if (o <= last_o + GUARD) begin
                check_val("guard_ser", serOut, IDLE);
                check_val("guard_busy", busy, 1);
                check_val("guard_frm_ready", frm_ready, 0);
                check_val("guard_done", done, 0);
            end else begin
                check_val("end_ser", serOut, IDLE);
                check_val("end_busy", busy, 0);
                check_val("end_frm_ready", frm_ready, 1);
                check_val("end_byte_ready", byte_ready, 0);
                check_val("end_done", done, 0);
            end
            byte_valid = 1'b0;
            if (k < nn) begin
                if (wh[k]) begin
                    if (o >= 8 + 8 * k) begin
                        k++;
                        gap = pick_gap(gap_fix);
                    end
                end else if (gap > 0) begin
                    gap--;
                end else begin
                    byte_valid = 1'b1;
                    byte_data = pay[k];
                    if (byte_ready === 1'b1) begin
                        hs++;
                        k++;
                        gap = pick_gap(gap_fix);
                    end
                end
            end
        end
        byte_valid = 1'b0;
        check_val("handshakes", hs, nn - nwh);
        last_done = t0 + last_o;
    endtask

    task automatic err_req(input logic [1:0] d);
        frm_dest = d;
        frm_len = 4'd0;
        frm_valid = 1'b1;
        step();
        frm_valid = 1'b0;
        check_val("err_pulse", err, 1);
        check_val("err_ser", serOut, IDLE);
        check_val("err_frm_ready", frm_ready, 1);
        check_val("err_busy", busy, 0);
        step();
        check_val("err_clear", err, 0);
        check_val("err_busy2", busy, 0);
    endtask

    initial begin
        logic [14:0] stream;
        logic [15:0] wh;
        int nidle;
        bit prev_frame;
        rst = 1'b1;
        frm_valid = 1'b0;
        frm_dest = 2'd0;
        frm_len = 4'd0;
        byte_valid = 1'b0;
        byte_data = 8'h00;
        repeat (3) step();
        check_val("rst_ser", serOut, IDLE);
        check_val("rst_frm_ready", frm_ready, 0);
        check_val("rst_byte_ready", byte_ready, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_err", err, 0);
        check_val("rst_underrun", underrun, 0);
        rst = 1'b0;
        step();
        check_val("post_rst_frm_ready", frm_ready, 1);

        run_frame(2'd2, 4'd1, 16'h0000, 0, 8'hA5, 1'b0);
        stream = 15'd0;
        for (int i = 0; i < 15 && i < last_bits.size(); i++) stream = {stream[13:0], last_bits[i]};
        check_val("a5_stream", stream, 15'b010000110100101);

        run_frame(2'd3, 4'd15, 16'h0000, 1, -1, 1'b1);
        err_req(2'd1);
        run_frame(2'd0, 4'd2, 16'h0002, 0, -1, 1'b0);

        frm_dest = 2'd1;
        frm_len = 4'd2;
        frm_valid = 1'b1;
        for (int o = 1; o <= 10; o++) begin
            step();
            frm_valid = 1'b0;
        end
        check_val("mid_busy", busy, 1);
        rst = 1'b1;
        step();
        check_val("abort_ser", serOut, IDLE);
        check_val("abort_busy", busy, 0);
        check_val("abort_frm_ready", frm_ready, 0);
        rst = 1'b0;
        step();
        check_val("abort_release_ready", frm_ready, 1);
        check_val("abort_release_ser", serOut, IDLE);
        run_frame(2'd1, 4'd3, 16'h0000, -1, -1, 1'b0);

        run_frame(2'd2, 4'd2, 16'h0000, -1, -1, 1'b1);
        run_frame(2'd0, 4'd1, 16'h0000, 0, -1, 1'b1);

        prev_frame = 1'b1;
        for (int r = 0; r < 14; r++) begin
            nidle = $urandom_range(0, 2);
            for (int i = 0; i < nidle; i++) idle_cycle();
            if ($urandom_range(0, 5) == 0) begin
                err_req(2'($urandom_range(0, 3)));
                prev_frame = 1'b0;
            end
            wh = 16'h0000;
            for (int s = 0; s < 16; s++) wh[s] = ($urandom_range(0, 7) == 0);
            run_frame(2'($urandom_range(0, 3)), 4'($urandom_range(1, 15)), wh, -1, -1,
                      prev_frame && nidle == 0);
            prev_frame = 1'b1;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog cycle=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog");
    end
endmodule
